// File: rtl/pfu.sv
// pfu - prefetch unit for the rv32i core.
//
// Issues sequential 32-bit instruction fetches on the instruction bus. It
// queues the responses, in order, in a small fetch FIFO. The FIFO head is
// presented to id_stage over the dav/pull handshake.
// The first entry after a redirect (reset or jump) carries sofr.
// A bus error marks its entry with ferr and halts fetching until the next jump.
//
// Ports
//   clk_i, resetb_i          clock, asynchronous active-low reset
//   clk_en_i                 global clock enable; all state holds when low
//   jump_i, jump_addr_i      redirect request and target from EX
//   ireqvalid_o/ireqready_i  fetch request handshake, address on ireqaddr_o
//   irspvalid_i, irspdata_i, irsperror_i
//                            in-order fetch response
//   pfu_dav_o, pfu_pull_i    head entry valid / consume head entry
//   pfu_sofr_o, pfu_ins_o, pfu_ferr_o, pfu_pc_o
//                            head entry fields
module pfu #(
    parameter int                P_XLEN         = 32,
    parameter int                P_FIFO_DEPTH   = 4,
    parameter logic [P_XLEN-1:0] P_RESET_VECTOR = '0
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    input  logic              jump_i,
    input  logic [P_XLEN-1:0] jump_addr_i,
    input  logic              ireqready_i,
    output logic              ireqvalid_o,
    output logic [P_XLEN-1:0] ireqaddr_o,
    input  logic              irspvalid_i,
    input  logic [31:0]       irspdata_i,
    input  logic              irsperror_i,
    output logic              pfu_dav_o,
    input  logic              pfu_pull_i,
    output logic              pfu_sofr_o,
    output logic [31:0]       pfu_ins_o,
    output logic              pfu_ferr_o,
    output logic [P_XLEN-1:0] pfu_pc_o
);

    localparam int                PW        = $clog2(P_FIFO_DEPTH);
    localparam int                CW        = PW + 1;
    localparam logic [CW:0]       DEPTH_W   = (CW+1)'(P_FIFO_DEPTH);
    localparam logic [CW-1:0]     C_ONE     = CW'(1);
    localparam logic [PW-1:0]     P_ONE     = PW'(1);
    localparam logic [P_XLEN-1:0] PC_STEP   = P_XLEN'(4);
    localparam logic [P_XLEN-1:0] ALIGN_MSK = P_XLEN'(3);

    logic [P_XLEN-1:0] fetch_pc;
    logic [P_XLEN-1:0] rsp_pc;
    logic [P_XLEN-1:0] fifo_pc  [P_FIFO_DEPTH];
    logic [31:0]       fifo_ins [P_FIFO_DEPTH];
    logic [P_FIFO_DEPTH-1:0] fifo_sofr;
    logic [P_FIFO_DEPTH-1:0] fifo_ferr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic              sofr_pend;
    logic              halted;

    logic [CW:0]       inflight;
    logic [P_XLEN-1:0] jump_tgt;
    logic              accept;
    logic              rsp;
    logic              do_jump;
    logic              do_drop;
    logic              do_write;
    logic              do_pop;

    assign pfu_dav_o  = (count != '0);
    assign ireqaddr_o = fetch_pc;
    assign pfu_sofr_o = fifo_sofr[rd_ptr];
    assign pfu_ferr_o = fifo_ferr[rd_ptr];
    assign pfu_ins_o  = fifo_ins[rd_ptr];
    assign pfu_pc_o   = fifo_pc[rd_ptr];

    always_comb begin
        // Queued plus in-flight entries are bounded by the FIFO depth.
        // As a result, every accepted request has a guaranteed slot.
        inflight    = {1'b0, count} + {1'b0, outstanding};
        ireqvalid_o = resetb_i & clk_en_i & ~halted & ~jump_i & (inflight < DEPTH_W);
        accept      = ireqvalid_o & ireqready_i;
        rsp         = clk_en_i & irspvalid_i;
        do_jump     = clk_en_i & jump_i;
        // Responses to requests issued before a redirect are dropped.
        do_drop     = rsp & (do_jump | (discard != '0));
        do_write    = rsp & ~do_drop;
        do_pop      = clk_en_i & ~jump_i & pfu_pull_i & pfu_dav_o;
        jump_tgt    = jump_addr_i & ~ALIGN_MSK;
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fetch_pc    <= P_RESET_VECTOR;
            rsp_pc      <= P_RESET_VECTOR;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            sofr_pend   <= 1'b1;
            halted      <= 1'b0;
            fifo_sofr   <= '0;
            fifo_ferr   <= '0;
            for (int unsigned i = 0; i < unsigned'(P_FIFO_DEPTH); i++) begin
                fifo_pc[i]  <= '0;
                fifo_ins[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rsp);

            // Whatever remains in flight after this cycle's response must be discarded.
            if (do_jump)
                discard <= outstanding - CW'(rsp);
            else if (rsp && (discard != '0))
                discard <= discard - C_ONE;

            if (do_jump) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                fetch_pc  <= jump_tgt;
                rsp_pc    <= jump_tgt;
                sofr_pend <= 1'b1;
                halted    <= 1'b0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + PC_STEP;

                if (do_write) begin
                    fifo_pc[wr_ptr]   <= rsp_pc;
                    fifo_ins[wr_ptr]  <= irspdata_i;
                    fifo_sofr[wr_ptr] <= sofr_pend;
                    fifo_ferr[wr_ptr] <= irsperror_i;
                    wr_ptr            <= wr_ptr + P_ONE;
                    rsp_pc            <= rsp_pc + PC_STEP;
                    sofr_pend         <= 1'b0;
                    if (irsperror_i)
                        halted <= 1'b1;
                end

                if (do_pop)
                    rd_ptr <= rd_ptr + P_ONE;

                case ({do_write, do_pop})
                    2'b10:   count <= count + C_ONE;
                    2'b01:   count <= count - C_ONE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pfu.sv
module tb_pfu;

    logic        clk_i = 1'b0;
    logic        resetb_i = 1'b0;
    logic        clk_en_i = 1'b1;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        ireqready_i = 1'b1;
    logic        ireqvalid_o;
    logic [31:0] ireqaddr_o;
    logic        irspvalid_i = 1'b0;
    logic [31:0] irspdata_i = '0;
    logic        irsperror_i = 1'b0;
    logic        pfu_dav_o;
    logic        pfu_pull_i = 1'b0;
    logic        pfu_sofr_o;
    logic [31:0] pfu_ins_o;
    logic        pfu_ferr_o;
    logic [31:0] pfu_pc_o;

    always #5 clk_i = ~clk_i;

    pfu #(
        .P_XLEN(32),
        .P_FIFO_DEPTH(4),
        .P_RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk_i(clk_i),
        .resetb_i(resetb_i),
        .clk_en_i(clk_en_i),
        .jump_i(jump_i),
        .jump_addr_i(jump_addr_i),
        .ireqready_i(ireqready_i),
        .ireqvalid_o(ireqvalid_o),
        .ireqaddr_o(ireqaddr_o),
        .irspvalid_i(irspvalid_i),
        .irspdata_i(irspdata_i),
        .irsperror_i(irsperror_i),
        .pfu_dav_o(pfu_dav_o),
        .pfu_pull_i(pfu_pull_i),
        .pfu_sofr_o(pfu_sofr_o),
        .pfu_ins_o(pfu_ins_o),
        .pfu_ferr_o(pfu_ferr_o),
        .pfu_pc_o(pfu_pc_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model: in-order responses, presented lat cycles after acceptance.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat = 1;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;
    logic        s_acc;
    logic        s_cons;
    logic [31:0] s_addr;

    task automatic to_sample();
        @(negedge clk_i);
        s_acc  = ireqvalid_o & ireqready_i;
        s_addr = ireqaddr_o;
        s_cons = irspvalid_i & clk_en_i;
    endtask

    task automatic to_edge();
        mreq_t r;
        @(posedge clk_i);
        #1;
        cyc++;
        if (s_cons && mq.size() > 0)
            r = mq.pop_front();
        if (s_acc) begin
            r.addr = s_addr;
            r.due  = cyc + lat - 1;
            mq.push_back(r);
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            irspvalid_i = 1'b1;
            irspdata_i  = ins_of(mq[0].addr);
            irsperror_i = err_en && (mq[0].addr == err_addr);
        end else begin
            irspvalid_i = 1'b0;
            irspdata_i  = '0;
            irsperror_i = 1'b0;
        end
    endtask

    task automatic do_reset(input int l);
        resetb_i    = 1'b0;
        clk_en_i    = 1'b1;
        jump_i      = 1'b0;
        jump_addr_i = '0;
        pfu_pull_i  = 1'b0;
        ireqready_i = 1'b1;
        irspvalid_i = 1'b0;
        irspdata_i  = '0;
        irsperror_i = 1'b0;
        err_en      = 1'b0;
        mq.delete();
        lat = l;
        #2;
        chk("rst ireqvalid", ireqvalid_o, 0);
        chk("rst ireqaddr", ireqaddr_o, 32'h0);
        chk("rst dav", pfu_dav_o, 0);
        chk("rst sofr", pfu_sofr_o, 0);
        chk("rst ins", pfu_ins_o, 0);
        chk("rst ferr", pfu_ferr_o, 0);
        chk("rst pc", pfu_pc_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        resetb_i = 1'b1;
    endtask

    // Leaves the bench at the sample point of the first cycle with dav=1.
    task automatic wait_dav(input string nm);
        int k = 0;
        to_sample();
        while (!pfu_dav_o && k < 20) begin
            to_edge();
            to_sample();
            k++;
        end
        chk({nm, " dav"}, pfu_dav_o, 1);
    endtask

    typedef struct {
        logic        pull;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic        exp_dav;
        logic [31:0] exp_pc;
        logic        exp_sofr;
    } vec_t;

    vec_t tv[11];

    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] prev_addr;
    logic        prev_stall;
    logic        first;
    logic        found;
    int          n_acc;

    initial begin
        // Reset fetch with 1-cycle memory: fill, stall, then two pulls.
        tv[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 1'b1};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0, 1'b1};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 1'b1};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 1'b1};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h8, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h8, 1'b0};
        tv[10] = '{1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h8, 1'b0};

        do_reset(1);
        for (int i = 0; i < 11; i++) begin
            pfu_pull_i  = tv[i].pull;
            ireqready_i = tv[i].ready;
            to_sample();
            chk($sformatf("t1[%0d] ireqvalid", i), ireqvalid_o, tv[i].exp_valid);
            chk($sformatf("t1[%0d] ireqaddr", i), ireqaddr_o, tv[i].exp_addr);
            chk($sformatf("t1[%0d] dav", i), pfu_dav_o, tv[i].exp_dav);
            if (tv[i].exp_dav) begin
                chk($sformatf("t1[%0d] pc", i), pfu_pc_o, tv[i].exp_pc);
                chk($sformatf("t1[%0d] sofr", i), pfu_sofr_o, tv[i].exp_sofr);
                chk($sformatf("t1[%0d] ins", i), pfu_ins_o, ins_of(tv[i].exp_pc));
                chk($sformatf("t1[%0d] ferr", i), pfu_ferr_o, 0);
            end
            to_edge();
        end
        pfu_pull_i = 1'b0;

        // Streaming with a pull every cycle; clock enable dropped for 3 cycles.
        do_reset(1);
        pfu_pull_i = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 24; i++) begin
            clk_en_i = !(i >= 12 && i < 15);
            to_sample();
            if (i >= 2) begin
                chk($sformatf("t2[%0d] dav", i), pfu_dav_o, 1);
                chk($sformatf("t2[%0d] pc", i), pfu_pc_o, exp_pc);
                chk($sformatf("t2[%0d] ireqvalid", i), ireqvalid_o, clk_en_i);
                if (clk_en_i)
                    exp_pc = exp_pc + 32'h4;
            end
            to_edge();
        end
        clk_en_i   = 1'b1;
        pfu_pull_i = 1'b0;

        // Jump while 3 requests are in flight (3-cycle memory). The jump coincides with a response.
        do_reset(3);
        repeat (3) begin
            to_sample();
            to_edge();
        end
        jump_i      = 1'b1;
        jump_addr_i = 32'h0000_0103;
        to_sample();
        chk("t3 jump ireqvalid", ireqvalid_o, 0);
        to_edge();
        jump_i = 1'b0;
        to_sample();
        chk("t3 redirect addr", ireqaddr_o, 32'h100);
        to_edge();
        wait_dav("t3 first");
        chk("t3 first pc", pfu_pc_o, 32'h100);
        chk("t3 first sofr", pfu_sofr_o, 1);
        chk("t3 first ins", pfu_ins_o, ins_of(32'h100));
        pfu_pull_i = 1'b1;
        to_edge();
        pfu_pull_i = 1'b0;
        wait_dav("t3 second");
        chk("t3 second pc", pfu_pc_o, 32'h104);
        chk("t3 second sofr", pfu_sofr_o, 0);
        to_edge();

        // Jump in the same cycle as a response and a pull.
        do_reset(1);
        repeat (3) begin
            to_sample();
            to_edge();
        end
        jump_i      = 1'b1;
        jump_addr_i = 32'h0000_0200;
        pfu_pull_i  = 1'b1;
        to_sample();
        chk("t4 rsp present", irspvalid_i, 1);
        chk("t4 pre dav", pfu_dav_o, 1);
        chk("t4 jump ireqvalid", ireqvalid_o, 0);
        to_edge();
        jump_i     = 1'b0;
        pfu_pull_i = 1'b0;
        to_sample();
        chk("t4 flushed dav", pfu_dav_o, 0);
        chk("t4 ireqaddr", ireqaddr_o, 32'h200);
        to_edge();
        wait_dav("t4 first");
        chk("t4 first pc", pfu_pc_o, 32'h200);
        chk("t4 first sofr", pfu_sofr_o, 1);
        to_edge();

        // Fetch error on 0x8, then recovery via jump to 0x40.
        do_reset(1);
        err_en     = 1'b1;
        err_addr   = 32'h8;
        pfu_pull_i = 1'b1;
        found      = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            to_sample();
            if (pfu_dav_o && pfu_pc_o == 32'h8)
                found = 1'b1;
            else
                to_edge();
        end
        chk("t5 reach 0x8", found, 1);
        chk("t5 ferr", pfu_ferr_o, 1);
        chk("t5 ins", pfu_ins_o, ins_of(32'h8));
        to_edge();
        for (int k = 0; k < 6; k++) begin
            to_sample();
            chk($sformatf("t5 halted[%0d] ireqvalid", k), ireqvalid_o, 0);
            to_edge();
        end
        jump_i      = 1'b1;
        jump_addr_i = 32'h40;
        to_sample();
        to_edge();
        jump_i = 1'b0;
        wait_dav("t5 resume");
        chk("t5 resume pc", pfu_pc_o, 32'h40);
        chk("t5 resume sofr", pfu_sofr_o, 1);
        chk("t5 resume ferr", pfu_ferr_o, 0);
        to_edge();

        // Random backpressure and random pulls across the address wrap. This also resets mid-operation.
        do_reset(2);
        jump_i      = 1'b1;
        jump_addr_i = 32'hFFFF_FFF8;
        to_sample();
        to_edge();
        jump_i     = 1'b0;
        exp_req    = 32'hFFFF_FFF8;
        exp_pc     = 32'hFFFF_FFF8;
        first      = 1'b1;
        prev_stall = 1'b0;
        prev_addr  = '0;
        n_acc      = 0;
        for (int i = 0; i < 80; i++) begin
            ireqready_i = 1'($urandom_range(0, 1));
            pfu_pull_i  = 1'($urandom_range(0, 1));
            to_sample();
            if (prev_stall) begin
                chk($sformatf("t6[%0d] held valid", i), ireqvalid_o, 1);
                chk($sformatf("t6[%0d] held addr", i), ireqaddr_o, prev_addr);
            end
            if (s_acc) begin
                chk($sformatf("t6[%0d] req addr", i), ireqaddr_o, exp_req);
                exp_req = exp_req + 32'h4;
                n_acc++;
            end
            if (pfu_dav_o && pfu_pull_i) begin
                chk($sformatf("t6[%0d] pop pc", i), pfu_pc_o, exp_pc);
                chk($sformatf("t6[%0d] pop sofr", i), pfu_sofr_o, first);
                chk($sformatf("t6[%0d] pop ins", i), pfu_ins_o, ins_of(exp_pc));
                exp_pc = exp_pc + 32'h4;
                first  = 1'b0;
            end
            chk($sformatf("t6[%0d] count bound", i), dut.count <= 4, 1);
            prev_stall = ireqvalid_o & ~ireqready_i;
            prev_addr  = ireqaddr_o;
            to_edge();
        end
        chk("t6 wrapped", n_acc >= 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
